// File: rtl/key_pkg.sv
// key_pkg: shared constants for the push-button front end.
//   KEY_CNT_MAX_DEF  - debounce stable time in cycles (20 ms at 50 MHz)
//   KEY_LONG_MAX_DEF - long-press hold time in cycles (1 s at 50 MHz)
//   KEY_ACTIVE_LVL   - pin level that means "pressed"
//   key_lvl_e        - debounced key level
package key_pkg;

  localparam int unsigned KEY_CNT_MAX_DEF  = 1_000_000;
  localparam int unsigned KEY_LONG_MAX_DEF = 50_000_000;
  localparam logic        KEY_ACTIVE_LVL   = 1'b0;

  typedef enum logic {
    KEY_UP   = 1'b0,
    KEY_DOWN = 1'b1
  } key_lvl_e;

endpackage

// File: rtl/key_debounce_ch.sv
// key_debounce_ch: one key channel -- 2-flop synchroniser, counter debounce,
// registered press/release pulses and, with KEY_LONG_PRESS_EN defined, a
// hold counter producing a single long-press pulse.
// Ports:
//   clk_i      - clock, rising edge
//   rst_i      - asynchronous active-high reset
//   key_i      - raw pin (KEY_ACTIVE_LVL = pressed)
//   state_o    - debounced level, 1 = pressed
//   press_o    - 1-cycle pulse when state_o rises
//   release_o  - 1-cycle pulse when state_o falls
//   long_o     - 1-cycle long-press pulse (0 when KEY_LONG_PRESS_EN undefined)
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int unsigned CNT_MAX  = KEY_CNT_MAX_DEF,
  parameter int unsigned CNT_W    = 20
`ifdef KEY_LONG_PRESS_EN
  ,
  parameter int unsigned LONG_MAX = KEY_LONG_MAX_DEF,
  parameter int unsigned LONG_W   = 26
`endif
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_i,
  output logic state_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  logic [1:0]       sync_q;
  logic             s_down;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  key_lvl_e         state_q, state_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

  // Synchroniser resets to the released pin level.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= {2{~KEY_ACTIVE_LVL}};
    end else begin
      sync_q <= {sync_q[0], key_i};
    end
  end

  assign s_down = (sync_q[1] == KEY_ACTIVE_LVL);

  // Any cycle agreeing with the committed level clears the count, so only an
  // uninterrupted run of CNT_MAX disagreeing cycles commits a new level.
  always_comb begin
    cnt_d     = '0;
    state_d   = state_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (s_down != (state_q == KEY_DOWN)) begin
      if (cnt_q == CNT_W'(CNT_MAX - 1)) begin
        state_d   = s_down ? KEY_DOWN : KEY_UP;
        press_d   = s_down;
        release_d = ~s_down;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      state_q   <= KEY_UP;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign state_o   = (state_q == KEY_DOWN);
  assign press_o   = press_q;
  assign release_o = release_q;

`ifdef KEY_LONG_PRESS_EN
  logic [LONG_W-1:0] hold_q;
  logic              long_q;

  // Counter parks at LONG_MAX-1, so the pulse fires once per press.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      long_q <= 1'b0;
      if (state_q == KEY_UP) begin
        hold_q <= '0;
      end else if (hold_q != LONG_W'(LONG_MAX - 1)) begin
        hold_q <= hold_q + 1'b1;
        long_q <= (hold_q == LONG_W'(LONG_MAX - 2));
      end
    end
  end

  assign long_o = long_q;
`else
  assign long_o = 1'b0;
`endif

endmodule

// File: rtl/key_debounce.sv
// key_debounce: push-button front end for KEY_NUM active-low pins.
// Optional long-press detection is built when KEY_LONG_PRESS_EN is defined.
// Ports:
//   sys_clk      - clock, rising edge
//   sys_rst      - asynchronous active-high reset
//   key          - raw pins, active-low
//   key_state    - debounced levels, active-high
//   key_press    - 1-cycle pulse per bit on 0->1 of key_state
//   key_release  - 1-cycle pulse per bit on 1->0 of key_state
//   key_long     - 1-cycle long-press pulse per bit (0 when compiled out)
module key_debounce
  import key_pkg::*;
#(
  parameter int unsigned KEY_NUM  = 2,
  parameter int unsigned CNT_MAX  = KEY_CNT_MAX_DEF,
  parameter int unsigned CNT_W    = 20,
  parameter int unsigned LONG_MAX = KEY_LONG_MAX_DEF,
  parameter int unsigned LONG_W   = 26
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic [KEY_NUM-1:0] key,
  output logic [KEY_NUM-1:0] key_state,
  output logic [KEY_NUM-1:0] key_press,
  output logic [KEY_NUM-1:0] key_release,
  output logic [KEY_NUM-1:0] key_long
);

  // Counters must be able to hold their terminal values.
  if ((CNT_MAX < 2) || (((64'(CNT_MAX) - 64'd1) >> CNT_W) != 64'd0)) begin : g_cnt_chk
    $error("key_debounce: CNT_W too narrow for CNT_MAX-1 or CNT_MAX < 2");
  end
  if ((LONG_MAX < 2) || (((64'(LONG_MAX) - 64'd1) >> LONG_W) != 64'd0)) begin : g_long_chk
    $error("key_debounce: LONG_W too narrow for LONG_MAX-1 or LONG_MAX < 2");
  end

  for (genvar i = 0; i < KEY_NUM; i++) begin : g_key
    key_debounce_ch #(
      .CNT_MAX  (CNT_MAX),
      .CNT_W    (CNT_W)
`ifdef KEY_LONG_PRESS_EN
      ,
      .LONG_MAX (LONG_MAX),
      .LONG_W   (LONG_W)
`endif
    ) u_ch (
      .clk_i     (sys_clk),
      .rst_i     (sys_rst),
      .key_i     (key[i]),
      .state_o   (key_state[i]),
      .press_o   (key_press[i]),
      .release_o (key_release[i]),
      .long_o    (key_long[i])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce with CNT_MAX=8, LONG_MAX=32, KEY_NUM=2.
// Reference model: a level is accepted when the pin, as seen through the
// two-cycle synchroniser delay, has shown the same pressed/released value
// for the last CNT_MAX samples and that value differs from the current level.
module tb_key_debounce;

  localparam int unsigned KN = 2;
  localparam int          CM = 8;
  localparam int          LM = 32;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic [KN-1:0] key     = '1;
  logic [KN-1:0] key_state, key_press, key_release, key_long;

  key_debounce #(
    .KEY_NUM  (KN),
    .CNT_MAX  (CM),
    .CNT_W    (4),
    .LONG_MAX (LM),
    .LONG_W   (6)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .key         (key),
    .key_state   (key_state),
    .key_press   (key_press),
    .key_release (key_release),
    .key_long    (key_long)
  );

  always #5 sys_clk = ~sys_clk;

  int checks   = 0;
  int failures = 0;
  int E        = 0;  // rising edges seen outside reset

  logic [KN-1:0] hist[$];  // pin samples, newest at the back
  logic [KN-1:0] m_state, m_press, m_rel, m_long;
  int            m_rise[KN];
  int            pc[KN], rc[KN], lc[KN], tp[KN], tr[KN], tl[KN];
  int            t0;

  task automatic chk(input string tag, input logic [KN-1:0] obs, input logic [KN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b edge=%0d", tag, obs, exp, E);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d edge=%0d", tag, obs, exp, E);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    repeat (CM + 2) hist.push_back('1);
    m_state = '0;
    m_press = '0;
    m_rel   = '0;
    m_long  = '0;
    for (int k = 0; k < KN; k++) m_rise[k] = 0;
  endtask

  task automatic model_edge();
    logic [KN-1:0] old;
    logic          v;
    bit            same;
    int            base;
    old = m_state;
    E++;
    hist.push_back(key);
    while (hist.size() > CM + 4) void'(hist.pop_front());
    m_press = '0;
    m_rel   = '0;
    m_long  = '0;
    base    = hist.size() - 3;  // sample taken two edges ago
    for (int k = 0; k < KN; k++) begin
`ifdef KEY_LONG_PRESS_EN
      if (old[k] && (E - m_rise[k] == LM - 1)) m_long[k] = 1'b1;
`endif
      v    = hist[base][k];
      same = 1'b1;
      for (int j = 1; j < CM; j++)
        if (hist[base - j][k] != v) same = 1'b0;
      if (same && ((~v) != old[k])) begin
        m_state[k] = ~v;
        if (~v) begin
          m_press[k] = 1'b1;
          m_rise[k]  = E;
        end else begin
          m_rel[k] = 1'b1;
        end
      end
    end
  endtask

  task automatic check_outputs();
    chk("key_state", key_state, m_state);
    chk("key_press", key_press, m_press);
    chk("key_release", key_release, m_rel);
    chk("key_long", key_long, m_long);
    chk("press_and_release", key_press & key_release, '0);
  endtask

  task automatic cyc();
    @(posedge sys_clk);
    model_edge();
    #1;
    check_outputs();
    for (int k = 0; k < KN; k++) begin
      if (key_press[k])   begin pc[k]++; tp[k] = E; end
      if (key_release[k]) begin rc[k]++; tr[k] = E; end
      if (key_long[k])    begin lc[k]++; tl[k] = E; end
    end
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic clr();
    for (int k = 0; k < KN; k++) begin
      pc[k] = 0; rc[k] = 0; lc[k] = 0;
      tp[k] = -1; tr[k] = -1; tl[k] = -1;
    end
  endtask

  // Asserts reset between edges and checks the outputs clear at once.
  task automatic do_reset();
    sys_rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    repeat (2) begin
      @(posedge sys_clk);
      #1;
      check_outputs();
    end
    @(negedge sys_clk);
    sys_rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr();
    key = 2'b11;
    do_reset();
    chk("reset_state", key_state, 2'b00);

    // Clean press on key 0
    clr(); key[0] = 1'b0; t0 = E; run(14);
    chk_int("s1_press_count", pc[0], 1);
    chk_int("s1_press_latency", tp[0] - t0, CM + 2);
    chk_int("s1_key1_events", pc[1] + rc[1], 0);
    chk("s1_state", key_state, 2'b01);

    // Clean release on key 0
    clr(); key[0] = 1'b1; t0 = E; run(14);
    chk_int("s2_release_count", rc[0], 1);
    chk_int("s2_release_latency", tr[0] - t0, CM + 2);
    chk_int("s2_press_count", pc[0], 0);
    chk("s2_state", key_state, 2'b00);

    // Bounce then settle low
    clr();
    repeat (4) begin
      key[0] = 1'b0; run(3);
      key[0] = 1'b1; run(2);
    end
    key[0] = 1'b0; t0 = E; run(14);
    chk_int("s3_press_count", pc[0], 1);
    chk_int("s3_press_latency", tp[0] - t0, CM + 2);
    chk_int("s3_release_count", rc[0] + rc[1], 0);

    // Glitch shorter than CNT_MAX on key 1
    clr(); key[1] = 1'b0; run(CM - 1); key[1] = 1'b1; run(14);
    chk_int("s4_glitch_events", pc[1] + rc[1], 0);
    chk("s4_state", key_state, 2'b01);
    key[0] = 1'b1; run(14);

    // Simultaneous press
    clr(); key = 2'b00; t0 = E; run(14);
    chk_int("s5_press0_latency", tp[0] - t0, CM + 2);
    chk_int("s5_press1_latency", tp[1] - t0, CM + 2);
    chk_int("s5_press_count", pc[0] + pc[1], 2);
    key = 2'b11; run(14);

    // Long hold of 60 cycles after the press commits
    clr(); key[0] = 1'b0; run(CM + 2); run(60);
`ifdef KEY_LONG_PRESS_EN
    chk_int("s6_long_count", lc[0], 1);
    chk_int("s6_long_delay", tl[0] - tp[0], LM - 1);
`else
    chk_int("s6_long_count_off", lc[0], 0);
`endif
    key[0] = 1'b1; run(14);

    // Short hold: released one cycle short of the long-press point
    clr(); key[0] = 1'b0; run(CM + 2); run(20); key[0] = 1'b1; run(14);
    chk_int("s6_short_hold_long", lc[0], 0);
    chk_int("s6_short_hold_press", pc[0], 1);

    // Reset mid-count on key 1 with key 0 pressed
    key[0] = 1'b0; run(14);
    clr(); key[1] = 1'b0; run(5);
    key[0] = 1'b1;
    do_reset();
    t0 = E; run(14);
    chk_int("s7_press1_count", pc[1], 1);
    chk_int("s7_press1_latency", tp[1] - t0, CM + 2);
    chk_int("s7_key0_events", pc[0] + rc[0], 0);
    key = 2'b11; run(14);

    // Randomised pin activity against the model
    clr();
    repeat (600) begin
      for (int k = 0; k < KN; k++)
        if ($urandom_range(15) == 0) key[k] = ~key[k];
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
